// File: rtl/logistic_synth.sv
// Multi-channel logistic-map synthesiser: shared-multiplier iteration FSM, swept r, NCO bank and
// sigma-delta mixer. Define LOGISTIC_SYNTH_PINGPONG_EN for a triangle r sweep instead of sawtooth.
module logistic_synth #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned FRAC       = 8,
  parameter int unsigned R_PERIOD   = 30000,
  parameter int unsigned PHASE_BITS = 16,
  parameter int unsigned LO_INC     = 8,
  parameter int unsigned HI_INC     = 48,
  parameter int unsigned PRESCALE   = 64,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en,
  output logic            snd,
  output logic            x_valid,
  output logic [CH_W-1:0] x_ch,
  output logic [FRAC-1:0] x_val
);

  localparam int unsigned RW    = FRAC + 2;
  localparam int unsigned PW    = RW + FRAC + 1;
  localparam int unsigned CNT_W = (R_PERIOD > 1) ? $clog2(R_PERIOD) : 1;
  localparam int unsigned PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned ACC_W = $clog2(N_CH + 1) + 1;
  localparam logic [RW-1:0] R_MIN = RW'((1 << FRAC) + (1 << (FRAC - 4)));
  localparam logic [RW-1:0] R_MAX = '1;

  typedef enum logic [1:0] {StIdle, StMulA, StMulB, StWrite} state_e;

  function automatic logic [PHASE_BITS-1:0] inc_of(input logic [FRAC-1:0] x);
    inc_of = PHASE_BITS'(LO_INC + (((HI_INC - LO_INC) * 32'(x)) >> FRAC));
  endfunction

  function automatic logic [FRAC-1:0] x_rst(input int k);
    x_rst = FRAC'((k + 1) << (FRAC - 4));
  endfunction

  state_e                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [FRAC-1:0]       t_q, t_d;
  logic [FRAC-1:0]       x_q [N_CH];
  logic [FRAC-1:0]       x_d [N_CH];
  logic [PHASE_BITS-1:0] inc_q [N_CH];
  logic [PHASE_BITS-1:0] inc_d [N_CH];
  logic [PHASE_BITS-1:0] phase_q [N_CH];
  logic [PHASE_BITS-1:0] phase_d [N_CH];
  logic [RW-1:0]         r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  snd_q, snd_d;
  logic                  x_valid_q, x_valid_d;
  logic [CH_W-1:0]       x_ch_q, x_ch_d;
  logic [FRAC-1:0]       x_val_q, x_val_d;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
  logic                  dir_up_q, dir_up_d;
`endif

  logic [FRAC-1:0] x_cur, x_new;
  logic [RW-1:0]   mul_a;
  logic [FRAC:0]   mul_b;
  logic [PW-1:0]   prod_sh;

  assign x_cur = x_q[ch_q];
  assign x_new = (t_q == '0) ? FRAC'(1) : t_q;

  // Single multiplier: x*(1-x) in MUL_A, r*p in MUL_B.
  always_comb begin
    mul_a = RW'(x_cur);
    mul_b = {1'b1, {FRAC{1'b0}}} - {1'b0, x_cur};
    if (state_q == StMulB) begin
      mul_a = r_q;
      mul_b = {1'b0, t_q};
    end
  end

  assign prod_sh = (PW'(mul_a) * PW'(mul_b)) >> FRAC;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    t_d       = t_q;
    x_d       = x_q;
    inc_d     = inc_q;
    x_valid_d = 1'b0;
    x_ch_d    = x_ch_q;
    x_val_d   = x_val_q;
    unique case (state_q)
      StIdle: if (en) state_d = StMulA;
      StMulA: begin
        t_d     = prod_sh[FRAC-1:0];
        state_d = StMulB;
      end
      StMulB: begin
        t_d     = (|prod_sh[PW-1:FRAC]) ? '1 : prod_sh[FRAC-1:0];
        state_d = StWrite;
      end
      StWrite: begin
        x_d[ch_q]   = x_new;
        inc_d[ch_q] = inc_of(x_new);
        x_valid_d   = 1'b1;
        x_ch_d      = ch_q;
        x_val_d     = x_new;
        ch_d        = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        state_d     = en ? StMulA : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    r_d   = r_q;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
    dir_up_d = dir_up_q;
`endif
    if (en) begin
      if (cnt_q == CNT_W'(R_PERIOD - 1)) begin
        cnt_d = '0;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
        if (dir_up_q) begin
          if (r_q == R_MAX) begin
            r_d      = R_MAX - 1'b1;
            dir_up_d = 1'b0;
          end else begin
            r_d = r_q + 1'b1;
          end
        end else if (r_q == R_MIN) begin
          r_d      = R_MIN + 1'b1;
          dir_up_d = 1'b1;
        end else begin
          r_d = r_q - 1'b1;
        end
`else
        r_d = (r_q == R_MAX) ? R_MIN : r_q + 1'b1;
`endif
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NCO bank and first-order sigma-delta mixer; both free-running.
  always_comb begin
    logic             tick;
    logic [ACC_W-1:0] s;
    logic [ACC_W-1:0] sum;
    tick    = (presc_q == PS_W'(PRESCALE - 1));
    presc_d = tick ? '0 : presc_q + 1'b1;
    s       = '0;
    for (int k = 0; k < N_CH; k++) begin
      phase_d[k] = tick ? phase_q[k] + inc_q[k] : phase_q[k];
      s          = s + ACC_W'(phase_q[k][PHASE_BITS-1]);
    end
    sum = acc_q + s;
    if (sum >= ACC_W'(N_CH)) begin
      snd_d = 1'b1;
      acc_d = sum - ACC_W'(N_CH);
    end else begin
      snd_d = 1'b0;
      acc_d = sum;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ch_q      <= '0;
      t_q       <= '0;
      r_q       <= R_MIN;
      cnt_q     <= '0;
      presc_q   <= '0;
      acc_q     <= '0;
      snd_q     <= 1'b0;
      x_valid_q <= 1'b0;
      x_ch_q    <= '0;
      x_val_q   <= '0;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
      dir_up_q  <= 1'b1;
`endif
      for (int k = 0; k < N_CH; k++) begin
        x_q[k]     <= x_rst(k);
        inc_q[k]   <= inc_of(x_rst(k));
        phase_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      t_q       <= t_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      presc_q   <= presc_d;
      acc_q     <= acc_d;
      snd_q     <= snd_d;
      x_valid_q <= x_valid_d;
      x_ch_q    <= x_ch_d;
      x_val_q   <= x_val_d;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
      dir_up_q  <= dir_up_d;
`endif
      x_q     <= x_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
    end
  end

  assign snd     = snd_q;
  assign x_valid = x_valid_q;
  assign x_ch    = x_ch_q;
  assign x_val   = x_val_q;

endmodule

// File: tb/tb_logistic_synth.sv
// Randomised-enable bench for logistic_synth with an arithmetic reference model of the map, r sweep,
// NCO bank and mixer, plus literal checks of the first iterations after reset.
module tb_logistic_synth;

  localparam int N    = 4;
  localparam int F    = 8;
  localparam int RP   = 16;
  localparam int PB   = 8;
  localparam int LO   = 8;
  localparam int HI   = 48;
  localparam int PS   = 3;
  localparam int RMIN = (1 << F) + (1 << (F - 4));
  localparam int RMAX = (1 << (F + 2)) - 1;
  localparam int NCYC = 30000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic       snd;
  logic       x_valid;
  logic [1:0] x_ch;
  logic [7:0] x_val;

  logistic_synth #(
    .N_CH(N), .FRAC(F), .R_PERIOD(RP), .PHASE_BITS(PB),
    .LO_INC(LO), .HI_INC(HI), .PRESCALE(PS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (en),
    .snd    (snd),
    .x_valid(x_valid),
    .x_ch   (x_ch),
    .x_val  (x_val)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: per-channel x, NCO phase, r sweep and the iteration's progress in clocks.
  int mx [N];
  int mph [N];
  int mr, mcnt, mpresc, macc, mdir_up;
  int mbusy, mch, mrused;
  bit exp_valid, exp_snd;
  int exp_ch, exp_val;

  function automatic int inc_of(int x);
    return LO + (((HI - LO) * x) >> F);
  endfunction

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, want);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mx[k]  = (k + 1) * 16;
      mph[k] = 0;
    end
    mr = RMIN; mcnt = 0; mpresc = 0; macc = 0; mdir_up = 1;
    mbusy = 0; mch = 0; mrused = 0;
    exp_valid = 0; exp_snd = 0; exp_ch = 0; exp_val = 0;
  endtask

  // One clock edge: mixer and NCOs see pre-edge values, then iteration, then the r sweep.
  task automatic model_step(input bit e);
    int s, p, y;
    s = 0;
    for (int k = 0; k < N; k++) s += (mph[k] >> (PB - 1)) & 1;
    macc += s;
    exp_snd = (macc >= N);
    if (exp_snd) macc -= N;
    if (mpresc == PS - 1) begin
      for (int k = 0; k < N; k++) mph[k] = (mph[k] + inc_of(mx[k])) % (1 << PB);
      mpresc = 0;
    end else mpresc++;

    exp_valid = 0;
    if (mbusy == 0) begin
      if (e) mbusy = 1;
    end else if (mbusy == 1) begin
      mbusy = 2;
    end else if (mbusy == 2) begin
      mrused = mr;
      mbusy  = 3;
    end else begin
      p = (mx[mch] * ((1 << F) - mx[mch])) >> F;
      y = (mrused * p) >> F;
      if (y > (1 << F) - 1) y = (1 << F) - 1;
      if (y == 0) y = 1;
      mx[mch] = y;
      exp_valid = 1; exp_ch = mch; exp_val = y;
      mch   = (mch + 1) % N;
      mbusy = e ? 1 : 0;
    end

    if (e) begin
      if (mcnt == RP - 1) begin
        mcnt = 0;
`ifdef LOGISTIC_SYNTH_PINGPONG_EN
        if (mdir_up != 0) begin
          if (mr == RMAX) begin mr = RMAX - 1; mdir_up = 0; end else mr++;
        end else begin
          if (mr == RMIN) begin mr = RMIN + 1; mdir_up = 1; end else mr--;
        end
`else
        mr = (mr == RMAX) ? RMIN : mr + 1;
`endif
      end else mcnt++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " snd"},     int'(snd),     0);
    check({tag, " x_valid"}, int'(x_valid), 0);
    check({tag, " x_ch"},    int'(x_ch),    0);
    check({tag, " x_val"},   int'(x_val),   0);
  endtask

  // Hand-computed first commits with r = 272 and x = 16, 32, 48, 64.
  int lit_val [4] = '{15, 29, 41, 51};

  initial begin
    int  base;
    bit  pulsed;
    int  rel;
    reset_n = 1'b0;
    en      = 1'b0;
    model_reset();
    #3;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    base   = 0;
    pulsed = 0;

    for (int cyc = 1; cyc <= NCYC; cyc++) begin
      rel = cyc - base;
      en  = (rel <= 13) ? 1'b1 : ($urandom_range(0, 99) < 92);
      @(posedge clk);
      model_step(en);
      #1;
      check("x_valid", int'(x_valid), int'(exp_valid));
      if (exp_valid) begin
        check("x_ch", int'(x_ch), exp_ch);
        check("x_val", int'(x_val), exp_val);
        check("x_val nonzero", int'(x_val != 0), 1);
      end
      check("snd", int'(snd), int'(exp_snd));
      if (rel == 4 || rel == 7 || rel == 10 || rel == 13) begin
        check("first x_valid", int'(x_valid), 1);
        check("first x_ch", int'(x_ch), (rel - 4) / 3);
        check("first x_val", int'(x_val), lit_val[(rel - 4) / 3]);
      end
      // Short asynchronous reset pulse while the product is in flight.
      if (!pulsed && cyc >= 15000 && mbusy == 2) begin
        pulsed = 1;
        #1 reset_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        model_reset();
        #1 reset_n = 1'b1;
        base = cyc;
      end
    end
    check("reset pulse seen", int'(pulsed), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
